mips16_trace_buffer: RTL and testbench
======================================

Name: mips16_trace_buffer

Overview:
- Downstream observer of the 16-bit MIPS core; consumes its pc_out and alu_result each clock.
- Captures one {pc, alu_result} record per new instruction into an on-chip FIFO, gated by a PC-match trigger state machine.
- Records drain through a valid/ready read port to a bench or debug readout.
- Lets the verification bench check execution traces without probing the core's internals.

Parameters:
- DEPTH, 16, number of trace entries; must be a power of 2.
- ADDR_W, 4, log2(DEPTH).
- OVF_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  16  core pc_out.
- alu_in  input  16  core alu_result.
- arm  input  1  one-cycle pulse; IDLE -> ARMED.
- stop  input  1  one-cycle pulse; ends capture.
- trig_pc  input  16  PC value that starts capture.
- rd_ready  input  1  consumer accepts the head record.
- rd_valid  output  1  head record is valid.
- rd_pc  output  16  head record PC.
- rd_alu  output  16  head record ALU result.
- count  output  ADDR_W+1  entries currently stored.
- overflow  output  OVF_W  records dropped because the FIFO was full; saturates.
- state  output  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

Behaviour:
- Reset (async, immediate; a mid-capture reset discards all entries):
  - state=IDLE, count=0, overflow=0, rd_valid=0, rd_pc=0, rd_alu=0.
  - Internal last_pc=16'hFFFF, rd/wr pointers=0.
- New-instruction detect: new_instr = (pc_in != last_pc). last_pc <= pc_in every cycle.
- State machine:
  - IDLE: arm -> ARMED. Otherwise hold.
  - ARMED:
    - new_instr && pc_in==trig_pc -> CAPTURE; the triggering record is written in that same cycle.
    - stop -> IDLE.
  - CAPTURE:
    - Each new_instr cycle writes {pc_in, alu_in}.
    - stop -> DONE. A record arriving on the stop cycle is still written.
  - DONE:
    - No writes. Reads continue.
    - arm -> ARMED. FIFO contents are kept; capture appends.
  - stop and arm in the same cycle: stop wins.
- Write rules:
  - Write when count<DEPTH.
  - Full and no read this cycle: record dropped, overflow += 1, saturating at all-ones.
  - Full with a read handshake in the same cycle: write accepted, count unchanged.
- Read port (first-word fall-through):
  - rd_valid = (count!=0).
  - rd_pc/rd_alu are combinational from mem[rd_ptr]; they are 0 when empty.
  - Handshake: rd_valid && rd_ready advances rd_ptr on the clock edge.
  - rd_valid may not drop without a handshake.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- count updates:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous read and write.
- Latency:
  - Record sampled at edge N is visible on rd_* after edge N when the FIFO was empty; count reflects it after the same edge.
  - Read of an empty FIFO is ignored (rd_ready with rd_valid=0 has no effect).
- Consecutive equal PCs (stalled core) produce one record only.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset 0, wraps) is stored with each record.
  - Extra output rd_ts [15:0] is presented with the head record; it is 0 when empty.
- Undefined: no counter, no rd_ts port; storage is 32 bits per entry.

Test Plan:
- Reset then arm, trig_pc=16'h0004, pc sequence 0,2,4,6,8 with alu=pc*3 -> first record {4,12}, then {6,18}, {8,24}; count=3; state=CAPTURE.
- pc held at 16'h0006 for 5 cycles during CAPTURE -> exactly one record for pc 6.
- DEPTH=16, 20 new PCs with rd_ready=0 -> count=16, overflow=4, rd_pc equals first captured PC.
- FIFO full, rd_ready=1 with a new PC in the same cycle -> count stays 16, overflow unchanged, head advances by one record.
- stop pulse after 3 records, further PC changes -> state=DONE, count=3; drain with rd_ready=1 gives 3 handshakes, then rd_valid=0.
- Reset asserted mid-CAPTURE with count=5 -> outputs immediately IDLE/0/0; after release, arm with no PC match -> stays ARMED, count=0.

Source files
------------

// File: rtl/mips16_trace_buffer.sv
//------------------------------------------------------------------------------
// Module   : mips16_trace_buffer
// Purpose  : PC-triggered execution trace FIFO for the 16-bit MIPS core.
//            Optional per-record cycle timestamp: define TRACE_TIMESTAMP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips16_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       alu_in,
  input  logic              arm,
  input  logic              stop,
  input  logic [15:0]       trig_pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [15:0]       rd_pc,
  output logic [15:0]       rd_alu,
  output logic [ADDR_W:0]   count,
  output logic [OVF_W-1:0]  overflow,
  output logic [1:0]        state
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]       rd_ts
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 48;
`else
  localparam int ENTRY_W = 32;
`endif

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [OVF_W-1:0]  OVF_ONE  = OVF_W'(1);
  localparam logic [OVF_W-1:0]  OVF_SAT  = '1;

  state_t              state_q, state_d;
  logic [15:0]         last_pc_q;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [OVF_W-1:0]    overflow_q, overflow_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];

  logic                new_instr;
  logic                wr_req;
  logic                wr_en;
  logic                rd_fire;
  logic                full;
  logic                drop;
  logic [ENTRY_W-1:0]  wr_data;
  logic [ENTRY_W-1:0]  head;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]         ts_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= 16'h0000;
    end else begin
      ts_q <= ts_q + 16'h0001;
    end
  end

  assign wr_data = {ts_q, pc_in, alu_in};
`else
  assign wr_data = {pc_in, alu_in};
`endif

  assign new_instr = (pc_in != last_pc_q);

  // Trigger FSM; stop beats arm, and in ARMED stop also beats a PC match.
  always_comb begin
    state_d = state_q;
    wr_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm && !stop) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (new_instr && (pc_in == trig_pc)) begin
          state_d = S_CAPTURE;
          wr_req  = 1'b1;
        end
      end
      S_CAPTURE: begin
        wr_req = new_instr;
        if (stop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (arm && !stop) begin
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a record if the head leaves in the same cycle.
  always_comb begin
    rd_fire    = (count_q != '0) && rd_ready;
    full       = (count_q == CNT_FULL);
    wr_en      = wr_req && (!full || rd_fire);
    drop       = wr_req && full && !rd_fire;
    rd_ptr_d   = rd_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d   = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en && !rd_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_fire && !wr_en) begin
      count_d = count_q - CNT_ONE;
    end
    if (drop && (overflow_q != OVF_SAT)) begin
      overflow_d = overflow_q + OVF_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_pc_q  <= 16'hFFFF;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      last_pc_q  <= pc_in;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_valid = (count_q != '0);
  assign rd_pc    = rd_valid ? head[31:16] : 16'h0000;
  assign rd_alu   = rd_valid ? head[15:0]  : 16'h0000;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts    = rd_valid ? head[47:32] : 16'h0000;
`endif

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips16_trace_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_mips16_trace_buffer
// Purpose  : Self-checking bench for mips16_trace_buffer with a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips16_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] alu_in = 16'h0000;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] trig_pc = 16'h0000;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_pc;
  logic [15:0] rd_alu;
  logic [4:0]  count;
  logic [7:0]  overflow;
  logic [1:0]  state;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  int checks = 0;
  int failures = 0;

  mips16_trace_buffer #(.DEPTH(16), .ADDR_W(4), .OVF_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .alu_in   (alu_in),
    .arm      (arm),
    .stop     (stop),
    .trig_pc  (trig_pc),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_pc    (rd_pc),
    .rd_alu   (rd_alu),
    .count    (count),
    .overflow (overflow),
    .state    (state)
`ifdef TRACE_TIMESTAMP_EN
    ,
    .rd_ts    (rd_ts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of records plus the trace-control mode.
  typedef struct packed {
    logic [15:0] ts;
    logic [15:0] pc;
    logic [15:0] alu;
  } rec_t;

  rec_t        m_q[$];
  int          m_state = 0;
  logic [15:0] m_last = 16'hFFFF;
  int          m_ovf = 0;
  logic [15:0] m_ts = 16'h0000;

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_last  = 16'hFFFF;
    m_ovf   = 0;
    m_ts    = 16'h0000;
  endtask

  task automatic model_update();
    bit   is_new;
    bit   rd;
    bit   want;
    bit   was_full;
    int   nxt;
    rec_t r;
    is_new   = (pc_in != m_last);
    rd       = (m_q.size() != 0) && rd_ready;
    want     = 1'b0;
    nxt      = m_state;
    was_full = (m_q.size() == 16);
    if (m_state == 0) begin
      if (arm && !stop) nxt = 1;
    end else if (m_state == 1) begin
      if (stop) nxt = 0;
      else if (is_new && pc_in == trig_pc) begin
        nxt  = 2;
        want = 1'b1;
      end
    end else if (m_state == 2) begin
      want = is_new;
      if (stop) nxt = 3;
    end else begin
      if (arm && !stop) nxt = 1;
    end
    if (rd) void'(m_q.pop_front());
    if (want) begin
      if (!was_full || rd) begin
        r.ts  = m_ts;
        r.pc  = pc_in;
        r.alu = alu_in;
        m_q.push_back(r);
      end else if (m_ovf < 255) begin
        m_ovf = m_ovf + 1;
      end
    end
    m_state = nxt;
    m_last  = pc_in;
    m_ts    = m_ts + 16'h0001;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    arm      = 1'b0;
    stop     = 1'b0;
    rd_ready = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || overflow !== 8'd0 || rd_valid !== 1'b0 ||
        rd_pc !== 16'h0 || rd_alu !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got st=%0d cnt=%0d ovf=%0d v=%b pc=%h alu=%h exp 0/0/0/0/0/0",
               state, count, overflow, rd_valid, rd_pc, rd_alu);
    end
  endtask

  task automatic test_trigger_capture();
    logic [15:0] seq [5];
    for (int i = 0; i < 5; i++) seq[i] = 16'(2 * i);
    do_reset();
    trig_pc = 16'h0004;
    pc_in   = 16'h0000;
    pulse_arm();
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL arm_state got=%0d exp=1", state);
    end
    for (int i = 0; i < 5; i++) begin
      pc_in  = seq[i];
      alu_in = 16'(seq[i] * 3);
      step();
    end
    checks++;
    if (count !== 5'd3 || state !== 2'd2 || rd_pc !== 16'h0004 || rd_alu !== 16'd12) begin
      failures++;
      $display("FAIL trigger_capture got cnt=%0d st=%0d pc=%h alu=%0d exp 3/2/0004/12",
               count, state, rd_pc, rd_alu);
    end
  endtask

  task automatic test_stall();
    // Continues from the capture above: head {4,12}, pc last seen 8.
    pc_in  = 16'h0006;
    alu_in = 16'd18;
    repeat (5) step();
    checks++;
    if (count !== 5'd4 || int'(count) != m_q.size()) begin
      failures++;
      $display("FAIL stall_one_record got cnt=%0d exp=4", count);
    end
    rd_ready = 1'b1;
    repeat (3) step();
    rd_ready = 1'b0;
    checks++;
    if (rd_pc !== 16'h0006 || rd_alu !== 16'd18 || count !== 5'd1) begin
      failures++;
      $display("FAIL stall_record got pc=%h alu=%0d cnt=%0d exp 0006/18/1", rd_pc, rd_alu, count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    trig_pc = 16'h0100;
    pc_in   = 16'h0000;
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      pc_in  = 16'(16'h0100 + 2 * i);
      alu_in = 16'(i);
      step();
    end
    checks++;
    if (count !== 5'd16 || overflow !== 8'd4 || rd_pc !== 16'h0100) begin
      failures++;
      $display("FAIL overflow got cnt=%0d ovf=%0d pc=%h exp 16/4/0100", count, overflow, rd_pc);
    end
  endtask

  task automatic test_full_read_write();
    pc_in    = 16'h0200;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 8'd4 || rd_pc !== 16'h0102 || rd_alu !== 16'd1) begin
      failures++;
      $display("FAIL full_rw got cnt=%0d ovf=%0d pc=%h alu=%0d exp 16/4/0102/1",
               count, overflow, rd_pc, rd_alu);
    end
    rd_ready = 1'b1;
    repeat (15) step();
    rd_ready = 1'b0;
    checks++;
    if (count !== 5'd1 || rd_pc !== 16'h0200) begin
      failures++;
      $display("FAIL full_rw_tail got cnt=%0d pc=%h exp 1/0200", count, rd_pc);
    end
  endtask

  task automatic test_stop_drain();
    logic [15:0] exp_pc [3];
    int          hs;
    exp_pc[0] = 16'h0010;
    exp_pc[1] = 16'h0012;
    exp_pc[2] = 16'h0014;
    do_reset();
    trig_pc = 16'h0010;
    pc_in   = 16'h0000;
    pulse_arm();
    for (int i = 0; i < 3; i++) begin
      pc_in = exp_pc[i];
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc_in = 16'(16'h0040 + 2 * i);
      step();
    end
    checks++;
    if (state !== 2'd3 || count !== 5'd3) begin
      failures++;
      $display("FAIL stop_done got st=%0d cnt=%0d exp 3/3", state, count);
    end
    rd_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 10 && rd_valid; i++) begin
      if (hs < 3) begin
        checks++;
        if (rd_pc !== exp_pc[hs]) begin
          failures++;
          $display("FAIL drain_pc idx=%0d got=%h exp=%h", hs, rd_pc, exp_pc[hs]);
        end
      end
      hs++;
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if (hs != 3 || rd_valid !== 1'b0 || rd_pc !== 16'h0) begin
      failures++;
      $display("FAIL drain_count got hs=%0d v=%b pc=%h exp 3/0/0000", hs, rd_valid, rd_pc);
    end
    // A read of an empty FIFO must be ignored.
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_read got cnt=%0d v=%b exp 0/0", count, rd_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    trig_pc = 16'h0020;
    pc_in   = 16'h0000;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      pc_in = 16'(16'h0020 + i);
      step();
    end
    checks++;
    if (count !== 5'd5 || state !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset got cnt=%0d st=%0d exp 5/2", count, state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || overflow !== 8'd0 || rd_valid !== 1'b0 || rd_pc !== 16'h0) begin
      failures++;
      $display("FAIL async_reset got st=%0d cnt=%0d ovf=%0d v=%b pc=%h exp 0/0/0/0/0000",
               state, count, overflow, rd_valid, rd_pc);
    end
    reset = 1'b0;
    model_reset();
    trig_pc = 16'h0099;
    pulse_arm();
    for (int i = 1; i < 4; i++) begin
      pc_in = 16'(i);
      step();
    end
    checks++;
    if (state !== 2'd1 || count !== 5'd0) begin
      failures++;
      $display("FAIL armed_nomatch got st=%0d cnt=%0d exp 1/0", state, count);
    end
  endtask

  task automatic test_random();
    logic [15:0] e_pc;
    logic [15:0] e_alu;
    int          mism;
    do_reset();
    trig_pc = 16'h0003;
    mism = 0;
    for (int t = 0; t < 800; t++) begin
      arm      = ($urandom_range(0, 11) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      rd_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) pc_in = 16'($urandom_range(0, 7));
      alu_in = 16'($urandom);
      step();
      e_pc  = (m_q.size() != 0) ? m_q[0].pc  : 16'h0;
      e_alu = (m_q.size() != 0) ? m_q[0].alu : 16'h0;
      checks++;
      if (int'(count) != m_q.size() || int'(overflow) != m_ovf || int'(state) != m_state ||
          rd_valid !== (m_q.size() != 0) || rd_pc !== e_pc || rd_alu !== e_alu) begin
        failures++;
        mism++;
        if (mism <= 10)
          $display("FAIL random t=%0d got cnt=%0d ovf=%0d st=%0d pc=%h alu=%h exp %0d/%0d/%0d/%h/%h",
                   t, count, overflow, state, rd_pc, rd_alu, m_q.size(), m_ovf, m_state, e_pc, e_alu);
      end
`ifdef TRACE_TIMESTAMP_EN
      checks++;
      if (rd_ts !== ((m_q.size() != 0) ? m_q[0].ts : 16'h0)) begin
        failures++;
        $display("FAIL random_ts t=%0d got=%h", t, rd_ts);
      end
`endif
    end
    arm      = 1'b0;
    stop     = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trigger_capture();
    test_stall();
    test_overflow();
    test_full_read_write();
    test_stop_drain();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
